// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB bus widths, transfer-type and slave-state enums
package ahb_pkg;
  localparam int AHB_AW = 21;
  localparam int AHB_DW = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  typedef enum logic {ADDR = 1'b0, WDATA = 1'b1} slv_state_t;
endpackage

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem: byte array, sync write port (we/waddr/wdata), registered read port (re/raddr -> rdata); not reset
module ahb_slv_mem #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: zero-wait AHB byte-SRAM responder; HCLK/HRESET(async), HADDR/HWRITE/HTRANS/HWDATA in, HRDATA out; AHB_SLV_STATS_EN adds wr_cnt/rd_cnt/err_cnt
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int              MEM_AW    = 10,
  parameter logic [AHB_AW-1:0] BASE_ADDR = 21'h000000
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [AHB_AW-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [AHB_DW-1:0] HWDATA,
  output logic [AHB_DW-1:0] HRDATA
`ifdef AHB_SLV_STATS_EN
  ,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       err_cnt
`endif
);
  slv_state_t state;
  logic [MEM_AW-1:0] pend_addr, off;
  logic [AHB_DW-1:0] mem_q, fwd_q;
  logic valid, hit, wr, rd, fwd, rd_zero, rd_fwd;
  assign valid = htrans_t'(HTRANS) == NONSEQ || htrans_t'(HTRANS) == SEQ;
  assign hit = HADDR[AHB_AW-1:MEM_AW] == BASE_ADDR[AHB_AW-1:MEM_AW];
  assign off = HADDR[MEM_AW-1:0];
  assign wr = valid && hit && HWRITE;
  assign rd = valid && hit && !HWRITE;
  // the memory returns the pre-write byte when a read meets the committing write
  assign fwd = rd && state == WDATA && pend_addr == off;
  // HRDATA is a mux of registered sources so reset forces 0 immediately
  assign HRDATA = rd_zero ? '0 : rd_fwd ? fwd_q : mem_q;
  ahb_slv_mem #(.AW(MEM_AW), .DW(AHB_DW)) u_mem (
    .clk(HCLK), .we(state == WDATA), .waddr(pend_addr), .wdata(HWDATA),
    .re(rd), .raddr(off), .rdata(mem_q)
  );
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ADDR;
      pend_addr <= '0;
      rd_zero <= 1'b1;
      rd_fwd <= 1'b0;
      fwd_q <= '0;
    end else begin
      state <= wr ? WDATA : ADDR;
      if (wr) pend_addr <= off;
      if (fwd) fwd_q <= HWDATA;
      if (rd) begin
        rd_zero <= 1'b0;
        rd_fwd <= fwd;
      end else if (valid && !hit && !HWRITE) rd_zero <= 1'b1;
    end
  end
`ifdef AHB_SLV_STATS_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (wr && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
      if (rd && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      if (valid && !hit && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif
endmodule
